// File: rtl/register_bank_pkg.sv
// register_bank_pkg: mode encoding and default sizing shared by the register bank.
package register_bank_pkg;
  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CHANNELS = 2;
endpackage

// File: rtl/register_bank_cell.sv
// register_cell: one channel flop with async reset, sync set and change-detect pulse.
module register_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic [WIDTH-1:0] set_val,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] q,
  output logic             upd
);
  logic [WIDTH-1:0] n;
  assign n = set ? set_val : nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q   <= '0;
      upd <= 1'b0;
    end else begin
      q   <= n;
      upd <= n != q;
    end
endmodule

// File: rtl/register_bank.sv
// register_bank: CHANNELS registers with load/rotate/shift/clear and per-channel update pulses.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int              WIDTH    = DEF_WIDTH,
  parameter int              CHANNELS = DEF_CHANNELS,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       ld_en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       upd
);
  mode_t m;
  assign m = mode_t'(mode);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    localparam int P = (i == 0) ? CHANNELS - 1 : i - 1;
    logic [WIDTH-1:0] cur, prv, din, shf, nxt;
    assign cur = q[i*WIDTH +: WIDTH];
    assign prv = q[P*WIDTH +: WIDTH];
    assign din = d[i*WIDTH +: WIDTH];
    // channel 0 is the serial input of the shift chain
    assign shf = (i == 0) ? din : prv;
    assign nxt = (m == MODE_LOAD)   ? (ld_en[i] ? din : cur) :
                 (m == MODE_ROTATE) ? prv :
                 (m == MODE_SHIFT)  ? shf :
                 (ld_en[i] ? '0 : cur);
    register_cell #(.WIDTH(WIDTH)) u_cell (
      .clk(clk), .rst(rst), .set(set), .set_val(SET_VAL), .nxt(nxt),
      .q(q[i*WIDTH +: WIDTH]), .upd(upd[i])
    );
  end
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed checks of a 2-channel and a 4-channel bank.
module tb_register_bank;
  import register_bank_pkg::*;
  logic clk = 0, rst = 1, set = 0, set4 = 0;
  logic [1:0] mode = MODE_LOAD, mode4 = MODE_LOAD;
  logic [1:0] ld_en = '0;
  logic [3:0] ld_en4 = '0;
  logic [15:0] d = '0, q;
  logic [31:0] d4 = '0, q4;
  logic [1:0] upd;
  logic [3:0] upd4;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  register_bank dut (
    .clk(clk), .rst(rst), .set(set), .mode(mode), .ld_en(ld_en), .d(d), .q(q), .upd(upd)
  );
  register_bank #(.WIDTH(8), .CHANNELS(4)) dut4 (
    .clk(clk), .rst(rst), .set(set4), .mode(mode4), .ld_en(ld_en4), .d(d4), .q(q4), .upd(upd4)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    #3;
    check("rst_q", q, 16'h0000);
    check("rst_upd", upd, 2'b00);
    @(negedge clk);
    rst = 0;
    set = 1; mode = MODE_LOAD; ld_en = 2'b11; d = 16'hF0AA;
    step();
    check("set_q", q, 16'hFFFF);
    check("set_upd", upd, 2'b11);
    set = 0; mode = MODE_CLEAR;
    step();
    check("clr_all_q", q, 16'h0000);
    mode = MODE_LOAD; ld_en = 2'b01; d = 16'hE3CC;
    step();
    check("load_q", q, 16'h00CC);
    check("load_upd", upd, 2'b01);
    step();
    check("load_same_q", q, 16'h00CC);
    check("load_same_upd", upd, 2'b00);
    ld_en = 2'b11; d = 16'hFCBB;
    step();
    check("preload_rot", q, 16'hFCBB);
    mode = MODE_ROTATE; ld_en = 2'b00; d = 16'h1234;
    step();
    check("rot1_q", q, 16'hBBFC);
    check("rot1_upd", upd, 2'b11);
    step();
    check("rot2_q", q, 16'hFCBB);
    mode = MODE_LOAD; ld_en = 2'b11; d = 16'hE4A3;
    step();
    check("preload_clr", q, 16'hE4A3);
    mode = MODE_CLEAR; ld_en = 2'b10;
    step();
    check("clr_q", q, 16'h00A3);
    check("clr_upd", upd, 2'b10);
    mode = MODE_ROTATE; set = 1;
    step();
    check("set_rot_q", q, 16'hFFFF);
    check("set_rot_upd", upd, 2'b11);
    set = 0;
    step();
    check("rot_ff_q", q, 16'hFFFF);
    check("rot_ff_upd", upd, 2'b00);
    #2 rst = 1;
    #1;
    check("midrst_q", q, 16'h0000);
    check("midrst_upd", upd, 2'b00);
    set = 1;
    step();
    check("rst_hold_q", q, 16'h0000);
    set = 0; rst = 0;
    step();
    check("post_rst_q", q, 16'h0000);
    check("post_rst_upd", upd, 2'b00);
    mode = MODE_LOAD; ld_en = 2'b01; d = 16'h005A;
    step();
    mode = MODE_ROTATE;
    step();
    check("resume_rot_q", q, 16'h5A00);
    check("resume_rot_upd", upd, 2'b11);
    mode4 = MODE_LOAD; ld_en4 = 4'hF; d4 = 32'h44332211;
    step();
    check("sh_pre_q", q4, 32'h44332211);
    mode4 = MODE_SHIFT; ld_en4 = 4'h0; d4 = 32'hFFFFFFA3;
    step();
    check("sh1_q", q4, 32'h332211A3);
    check("sh1_upd", upd4, 4'hF);
    d4 = 32'h000000E4;
    step();
    check("sh2_q", q4, 32'h2211A3E4);
    mode4 = MODE_ROTATE;
    step();
    check("rot4_1_q", q4, 32'h11A3E422);
    step();
    step();
    step();
    check("rot4_4_q", q4, 32'h2211A3E4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per channel (1..64).
REQ-002 SHALL have parameter CHANNELS, default 2, number of registers (2..16).
REQ-003 SHALL have parameter SET_VAL, default all-ones of WIDTH, value loaded by set.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port set  input  1  synchronous set of all channels to SET_VAL.
REQ-007 SHALL have port mode  input  2  operation select: 00 LOAD, 01 ROTATE, 10 SHIFT, 11 CLEAR.
REQ-008 SHALL have port ld_en  input  CHANNELS  per-channel enable for LOAD and CLEAR; bit i selects channel i.
REQ-009 SHALL have port d  input  CHANNELS*WIDTH  data; channel i in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port q  output  CHANNELS*WIDTH  registered channel contents, same packing as d.
REQ-011 SHALL have port upd  output  CHANNELS  registered one-cycle pulse per channel whose q value changed on the previous edge.

Function
REQ-012 Priority per edge SHALL be: rst (async) > set > mode operation.
REQ-013 set=1 SHALL load SET_VAL into every channel regardless of mode and ld_en.
REQ-014 LOAD: channel i SHALL take d[i] when ld_en[i]=1, else hold; channels independent.
REQ-015 ROTATE: q[i] SHALL take old q[i-1] for i>0, q[0] SHALL take old q[CHANNELS-1]; ld_en ignored; all channels move simultaneously using pre-edge values.
REQ-016 SHIFT: q[0] SHALL take d[0], q[i] SHALL take old q[i-1]; old q[CHANNELS-1] discarded; ld_en and d[i>0] ignored.
REQ-017 CLEAR: channel i SHALL go to 0 when ld_en[i]=1, else hold.
REQ-018 Latency d->q SHALL be exactly one clock edge; q SHALL have no combinational path from any input.
REQ-019 upd[i] SHALL be 1 in the cycle after an edge where q[i] new value differs from old value, 0 otherwise; a write of an equal value SHALL NOT pulse upd.
REQ-020 Persistent mode/ld_en SHALL repeat the operation every cycle (e.g. held ROTATE keeps rotating; CHANNELS edges return to start pattern).
REQ-021 CHANNELS=2 ROTATE SHALL be an exact swap of q[0] and q[1].
REQ-022 set during ROTATE/SHIFT SHALL win that edge; operation resumes next edge from SET_VAL contents.
REQ-023 Unknown/X on mode SHALL not be required to be handled; no illegal encodings exist.

Reset
REQ-024 rst=1 SHALL immediately force all q to 0 and all upd to 0, independent of clk.
REQ-025 While rst=1, set, mode, ld_en and d SHALL have no effect.
REQ-026 Reset asserted mid-operation (e.g. during ROTATE) SHALL discard all channel state; after release the first active edge applies the then-current set/mode from zero contents.
REQ-027 The transition of q to 0 caused by rst SHALL NOT produce an upd pulse after release.

Structure
REQ-028 A shared package register_bank_pkg SHALL hold the mode encoding type (MODE_LOAD, MODE_ROTATE, MODE_SHIFT, MODE_CLEAR) and default WIDTH/CHANNELS constants.
REQ-029 Next-value selection per channel SHALL be combinational in register_bank; storage SHALL be one sub-module register_cell (WIDTH-wide flop with async rst, sync set, next-value input, change-detect upd output), instantiated CHANNELS times by generate.

Verification (WIDTH=8; CHANNELS=2 unless stated)
REQ-030 Reset/set: rst=1 -> q=0x00/0x00 at once without clock; release, set=1, mode=LOAD, ld_en=11, d=AA/F0 -> q=FF/FF after one edge (set wins), upd=11 next cycle.
REQ-031 LOAD independence: q=00/00, ld_en=01, d0=CC, d1=E3 -> q0=CC, q1=00, upd=01; repeat same stimulus -> q unchanged, upd=00.
REQ-032 ROTATE swap: q0=BB, q1=FC, mode=ROTATE -> q0=FC, q1=BB after one edge, back to BB/FC after two.
REQ-033 SHIFT with CHANNELS=4: q=11/22/33/44 (ch0..3), mode=SHIFT, d0=A3 -> q=A3/11/22/33; second edge d0=E4 -> E4/A3/11/22.
REQ-034 CLEAR and async reset mid-run: q0=A3, q1=E4, mode=CLEAR, ld_en=10 -> q0=A3, q1=00; then ROTATE running, rst pulsed between edges -> q=00/00 immediately, upd=00, rotation resumes from zero after release.
